ep8_packetizer: RTL and testbench

Frames controller replies into the byte stream sent to the host on FX2 endpoint 8. It sits between the controller's EP8 command-output port and the FX2 slave-FIFO write path. A packet is started with a header (command ID and 16-bit length). The block then emits a 3-byte header followed by exactly `length` payload bytes, which are buffered in an internal FIFO. Output uses a valid/ready byte handshake.

---
 rtl/ep8_packetizer_pkg.sv | 16 +
 rtl/ep8_packetizer_byte_fifo.sv | 54 +++++
 rtl/ep8_packetizer.sv | 205 ++++++++++++++++++++
 tb/tb_ep8_packetizer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/ep8_packetizer_pkg.sv
// Shared types and constants for the EP8 reply packetizer.
package ep8_packetizer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HDR_ID  = 3'd1,
        ST_HDR_HI  = 3'd2,
        ST_HDR_LO  = 3'd3,
        ST_PAYLOAD = 3'd4
    } state_t;

    localparam int HDR_BYTES = 3;

    typedef logic [15:0] len_t;

endpackage

// File: rtl/ep8_packetizer_byte_fifo.sv
// Single-clock byte FIFO with wrap-bit pointers and a registered read port.
module byte_fifo #(
    parameter int DEPTH = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push_i,
    input  logic [7:0] wdata_i,
    input  logic       pop_i,
    output logic [7:0] rdata_o,
    output logic       full_o,
    output logic       empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]  mem_q [DEPTH];
    logic [AW:0] wr_ptr_q;
    logic [AW:0] rd_ptr_q;
    logic [7:0]  rdata_q;
    logic        do_push;
    logic        do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop_i && !empty_o;
    // A pop frees the slot the same edge, so push-on-full is safe alongside it.
    assign do_push = push_i && (!full_o || do_pop);
    assign rdata_o = rdata_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            rdata_q  <= 8'h00;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
                rdata_q  <= mem_q[rd_ptr_q[AW-1:0]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/ep8_packetizer.sv
// Frames EP8 replies as {id, len_hi, len_lo, payload...} onto a registered
// valid/ready byte stream; payload is buffered in byte_fifo.
module ep8_packetizer
    import ep8_packetizer_pkg::*;
#(
    parameter int BUF_DEPTH = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ep8_start,
    input  logic [7:0]  ep8_cmd_id,
    input  logic [15:0] ep8_cmd_length,
    output logic        ep8_ready,
    input  logic        ep8_write,
    input  logic [7:0]  ep8_data,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic        busy,
    output logic        err
);

    state_t     state_q, state_d;
    logic [7:0] id_q, id_d;
    len_t       len_q, len_d;
    len_t       wr_cnt_q, wr_cnt_d;
    len_t       rd_cnt_q, rd_cnt_d;
    logic [7:0] out_data_q, out_data_d;
    logic       out_valid_q, out_valid_d;
    logic       out_last_q, out_last_d;
    logic       pend_q, pend_d;
    logic       pend_last_q, pend_last_d;
    logic       err_q, err_d;

    logic       busy_s;
    logic       ready_s;
    logic       load_en;
    logic       consume;
    logic       fifo_push;
    logic       fifo_pop;
    logic       fifo_full;
    logic       fifo_empty;
    logic [7:0] fifo_rdata;

    // pend_q marks that the FIFO read register holds a byte not yet moved to the output.
    assign busy_s    = (state_q != ST_IDLE) || out_valid_q;
    assign ready_s   = busy_s && !fifo_full && (wr_cnt_q != len_q);
    assign load_en   = !out_valid_q || out_ready;
    assign consume   = (state_q == ST_PAYLOAD) && load_en && pend_q;
    assign fifo_push = ep8_write && ready_s;
    assign fifo_pop  = ((state_q == ST_HDR_LO && !pend_q) ||
                        (state_q == ST_PAYLOAD && (!pend_q || load_en))) &&
                       !fifo_empty && (rd_cnt_q != len_q);

    byte_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (fifo_push),
        .wdata_i (ep8_data),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // State and datapath register bank.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            id_q        <= 8'h00;
            len_q       <= 16'h0000;
            wr_cnt_q    <= 16'h0000;
            rd_cnt_q    <= 16'h0000;
            out_data_q  <= 8'h00;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            pend_q      <= 1'b0;
            pend_last_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            id_q        <= id_d;
            len_q       <= len_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            pend_q      <= pend_d;
            pend_last_q <= pend_last_d;
            err_q       <= err_d;
        end
    end

    // Next-state: the state names the byte to load next into the output register.
    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        len_d       = len_q;
        wr_cnt_d    = wr_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        pend_d      = pend_q;
        pend_last_d = pend_last_q;
        err_d       = err_q;

        if ((ep8_write && !ready_s) || (ep8_start && busy_s)) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end

        if (fifo_push) begin
            wr_cnt_d = wr_cnt_q + 16'd1;
        end else begin
            wr_cnt_d = wr_cnt_q;
        end

        if (fifo_pop) begin
            rd_cnt_d    = rd_cnt_q + 16'd1;
            pend_d      = 1'b1;
            pend_last_d = (rd_cnt_q == (len_q - 16'd1));
        end else if (consume) begin
            pend_d = 1'b0;
        end else begin
            pend_d = pend_q;
        end

        // An accepted (or absent) output byte empties the slot unless refilled below.
        if (load_en) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
            out_last_d  = out_last_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (ep8_start && !busy_s) begin
                    id_d     = ep8_cmd_id;
                    len_d    = ep8_cmd_length;
                    wr_cnt_d = 16'h0000;
                    rd_cnt_d = 16'h0000;
                    pend_d   = 1'b0;
                    state_d  = ST_HDR_ID;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HDR_ID: begin
                if (load_en) begin
                    out_data_d  = id_q;
                    out_valid_d = 1'b1;
                    state_d     = ST_HDR_HI;
                end else begin
                    state_d = ST_HDR_ID;
                end
            end
            ST_HDR_HI: begin
                if (load_en) begin
                    out_data_d  = len_q[15:8];
                    out_valid_d = 1'b1;
                    state_d     = ST_HDR_LO;
                end else begin
                    state_d = ST_HDR_HI;
                end
            end
            ST_HDR_LO: begin
                if (load_en) begin
                    out_data_d  = len_q[7:0];
                    out_valid_d = 1'b1;
                    out_last_d  = (len_q == 16'h0000);
                    state_d     = (len_q == 16'h0000) ? ST_IDLE : ST_PAYLOAD;
                end else begin
                    state_d = ST_HDR_LO;
                end
            end
            ST_PAYLOAD: begin
                if (consume) begin
                    out_data_d  = fifo_rdata;
                    out_valid_d = 1'b1;
                    out_last_d  = pend_last_q;
                    state_d     = pend_last_q ? ST_IDLE : ST_PAYLOAD;
                end else begin
                    state_d = ST_PAYLOAD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign ep8_ready = ready_s;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign busy      = busy_s;
    assign err       = err_q;

endmodule

// File: tb/tb_ep8_packetizer.sv
// Directed bench for ep8_packetizer: table of packets plus reset-mid-packet sequence.
module tb_ep8_packetizer;
    import ep8_packetizer_pkg::*;

    logic        clk;
    logic        reset;
    logic        ep8_start;
    logic [7:0]  ep8_cmd_id;
    logic [15:0] ep8_cmd_length;
    logic        ep8_ready;
    logic        ep8_write;
    logic [7:0]  ep8_data;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        busy;
    logic        err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0]  id;
        logic [15:0] len;
        logic [7:0]  d0;
        int          mode;       // 0: out_ready high, 1: random, 2: low for 'stall' cycles
        int          stall;
        bit          inject;     // extra write past length and a start while busy
        int          exp_block;  // writes done when ep8_ready first blocks, -1 if never
        bit          exp_err;
    } vec_t;

    vec_t vecs [5];

    ep8_packetizer #(.BUF_DEPTH(64)) dut (
        .clk            (clk),
        .reset          (reset),
        .ep8_start      (ep8_start),
        .ep8_cmd_id     (ep8_cmd_id),
        .ep8_cmd_length (ep8_cmd_length),
        .ep8_ready      (ep8_ready),
        .ep8_write      (ep8_write),
        .ep8_data       (ep8_data),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_last       (out_last),
        .busy           (busy),
        .err            (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_byte(input vec_t v, input int idx);
        logic [7:0] b;
        case (idx)
            0:       b = v.id;
            1:       b = v.len[15:8];
            2:       b = v.len[7:0];
            default: b = v.d0 + 8'(idx - HDR_BYTES);
        endcase
        return b;
    endfunction

    task automatic run_packet(input vec_t v);
        int         total;
        int         got;
        int         wrote;
        int         first_block;
        int         first_it;
        int         last_it;
        int         it;
        bit         held;
        bit         injected;
        logic [7:0] held_data;
        logic       held_last;
        total = int'(v.len) + HDR_BYTES;
        got = 0; wrote = 0; first_block = -1; first_it = -1; last_it = -1;
        it = 0; held = 1'b0; injected = 1'b0; held_data = 8'h00; held_last = 1'b0;

        ep8_cmd_id     = v.id;
        ep8_cmd_length = v.len;
        ep8_start      = 1'b1;
        @(negedge clk);
        ep8_start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("hdr_latency", 32'(out_valid), 32'd0);

        while (got < total && it < 2000) begin
            case (v.mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = (it >= v.stall);
            endcase
            if (held) begin
                chk("stall_valid", 32'(out_valid), 32'd1);
                chk("stall_data", 32'(out_data), 32'(held_data));
                chk("stall_last", 32'(out_last), 32'(held_last));
            end
            held      = out_valid && !out_ready;
            held_data = out_data;
            held_last = out_last;
            if (out_valid && out_ready) begin
                chk("stream_byte", 32'(out_data), 32'(exp_byte(v, got)));
                chk("stream_last", 32'(out_last), 32'(got == total - 1));
                if (got == 0) first_it = it;
                last_it = it;
                got++;
            end
            if (wrote < int'(v.len) && ep8_ready) begin
                ep8_write = 1'b1;
                ep8_data  = v.d0 + 8'(wrote);
                wrote++;
            end else if (wrote < int'(v.len)) begin
                ep8_write = 1'b0;
                if (first_block < 0) first_block = wrote;
            end else if (v.inject && !injected) begin
                ep8_write = 1'b1;
                ep8_data  = 8'hEE;
                injected  = 1'b1;
            end else begin
                ep8_write = 1'b0;
            end
            ep8_start = v.inject && (it == 2);
            if (ep8_start) begin
                ep8_cmd_id     = 8'h77;
                ep8_cmd_length = 16'd9;
            end
            @(negedge clk);
            it++;
        end
        ep8_write = 1'b0;
        ep8_start = 1'b0;
        out_ready = 1'b1;

        chk("bytes_received", 32'(got), 32'(total));
        chk("busy_drop", 32'(busy), 32'd0);
        chk("valid_drop", 32'(out_valid), 32'd0);
        chk("err_flag", 32'(err), 32'(v.exp_err));
        chk("ready_block", 32'(first_block), 32'(v.exp_block));
        if (v.mode == 0) begin
            chk("first_byte_cycle", 32'(first_it), 32'd1);
            chk("throughput_span", 32'(last_it - first_it), 32'(total - 1));
        end
    endtask

    initial begin
        int   got;
        int   wrote;
        vec_t v33;

        vecs[0] = '{id: 8'h21, len: 16'd0,   d0: 8'h00, mode: 0, stall: 0,  inject: 1'b0, exp_block: -1, exp_err: 1'b0};
        vecs[1] = '{id: 8'h05, len: 16'd4,   d0: 8'hA0, mode: 0, stall: 0,  inject: 1'b0, exp_block: -1, exp_err: 1'b0};
        vecs[2] = '{id: 8'h3C, len: 16'd100, d0: 8'h10, mode: 2, stall: 80, inject: 1'b0, exp_block: 64, exp_err: 1'b0};
        vecs[3] = '{id: 8'h9E, len: 16'd10,  d0: 8'hC0, mode: 1, stall: 0,  inject: 1'b0, exp_block: -1, exp_err: 1'b0};
        vecs[4] = '{id: 8'h5B, len: 16'd4,   d0: 8'h70, mode: 0, stall: 0,  inject: 1'b1, exp_block: -1, exp_err: 1'b1};
        v33     = '{id: 8'h33, len: 16'd1,   d0: 8'h5A, mode: 0, stall: 0,  inject: 1'b0, exp_block: -1, exp_err: 1'b0};

        reset = 1'b1; ep8_start = 1'b0; ep8_cmd_id = 8'h00; ep8_cmd_length = 16'h0000;
        ep8_write = 1'b0; ep8_data = 8'h00; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_ep8_ready", 32'(ep8_ready), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            run_packet(vecs[i]);
        end

        // Abandon an 8-byte packet once the header and two payload bytes are out.
        ep8_cmd_id = 8'h40; ep8_cmd_length = 16'd8; ep8_start = 1'b1;
        @(negedge clk);
        ep8_start = 1'b0;
        got = 0; wrote = 0;
        for (int it = 0; it < 100 && got < 5; it++) begin
            out_ready = 1'b1;
            if (out_valid) got++;
            if (wrote < 8 && ep8_ready) begin
                ep8_write = 1'b1;
                ep8_data  = 8'h80 + 8'(wrote);
                wrote++;
            end else begin
                ep8_write = 1'b0;
            end
            @(negedge clk);
        end
        ep8_write = 1'b0;
        chk("mid_bytes_out", 32'(got), 32'd5);
        chk("mid_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_out_data", 32'(out_data), 32'd0);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_out_last", 32'(out_last), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_err", 32'(err), 32'd0);
        chk("mid_rst_ep8_ready", 32'(ep8_ready), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run_packet(v33);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
